// File: rtl/psram_data_bridge.sv
// ============================================================================
// psram_data_bridge
// ----------------------------------------------------------------------------
// Connects the rv32i memory-access stage to a 16-bit cellular PSRAM
// controller. One 32-bit load or store is accepted at a time and split into
// up to two halfword transactions (low half first, then high half). Halves
// with no enabled bytes are skipped entirely. Read halfwords are reassembled
// into a 32-bit word, and a one-cycle completion pulse ends the access. A
// transaction that waits longer than TIMEOUT_CYCLES is abandoned, and the
// access completes with an error pulse.
//
// Ports
//   clk, reset_n        core clock, asynchronous active-low reset
//   req_valid           access request, held stable until req_ready
//   req_we              1 = store, 0 = load
//   req_addr[31:0]      byte address; bits [22:2] select the word
//   req_wdata[31:0]     lane-aligned store data
//   req_be[3:0]         lane-aligned byte enables
//   req_ready           one-cycle completion pulse
//   req_err             pulses with req_ready when the access timed out
//   rdata[31:0]         load data, valid with req_ready, held until next
//   stall               req_valid & ~req_ready, freezes the core pipeline
//   ps_addr[21:0]       halfword address {word, half}
//   ps_write_en         single-cycle write command
//   ps_read_en          single-cycle read command
//   ps_data_in[15:0]    write halfword
//   ps_write_high_byte  byte strobe, bits [15:8] of the halfword
//   ps_write_low_byte   byte strobe, bits [7:0] of the halfword
//   ps_read_avail       read data valid pulse from the controller
//   ps_data_out[15:0]   read halfword from the controller
//   ps_busy             controller busy
// ============================================================================
module psram_data_bridge #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        req_err,
    output logic [31:0] rdata,
    output logic        stall,
    output logic [21:0] ps_addr,
    output logic        ps_write_en,
    output logic        ps_read_en,
    output logic [15:0] ps_data_in,
    output logic        ps_write_high_byte,
    output logic        ps_write_low_byte,
    input  logic        ps_read_avail,
    input  logic [15:0] ps_data_out,
    input  logic        ps_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE_LO, S_WAIT_LO, S_ISSUE_HI, S_WAIT_HI, S_DONE, S_ERR
    } state_t;

    // Terminal count of the per-transaction wait counter (11-bit counter).
    localparam logic [10:0] C_WAIT_LAST = 11'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic        r_we;
    logic [20:0] r_word_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_shadow;
    logic [10:0] r_cnt;

    logic        w_we;
    logic [20:0] w_word_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_lo_needed;
    logic        w_hi_needed;
    logic        w_cmd_hi;
    logic        w_pulsing;
    logic        w_wait_done;
    logic [1:0]  w_rd_be;
    logic [15:0] w_rd_masked;
    logic [31:0] w_shadow_next;
    logic        w_fire;
    logic        w_unused_addr_bits;

    assign stall = req_valid & ~req_ready;

    // Address bits outside the word index are intentionally ignored.
    assign w_unused_addr_bits = ^{req_addr[31:23], req_addr[1:0]};

    // In IDLE the request is not latched yet, so a command issued on the
    // accept edge must take its fields straight from the request port.
    assign w_we        = (r_state == S_IDLE) ? req_we          : r_we;
    assign w_word_addr = (r_state == S_IDLE) ? req_addr[22:2]  : r_word_addr;
    assign w_wdata     = (r_state == S_IDLE) ? req_wdata       : r_wdata;
    assign w_be        = (r_state == S_IDLE) ? req_be          : r_be;
    assign w_lo_needed = |w_be[1:0];
    assign w_hi_needed = |w_be[3:2];

    // Half targeted by a command fired this cycle: only IDLE (skipping an
    // empty low half) and ISSUE_LO can target the low half.
    assign w_cmd_hi  = (r_state == S_IDLE) ? ~w_lo_needed : (r_state != S_ISSUE_LO);
    assign w_pulsing = ps_write_en | ps_read_en;

    // Stores ignore busy on the first wait cycle: the controller only raises
    // busy the cycle after it sees the command.
    assign w_wait_done = r_we ? ((r_cnt != 11'd0) && !ps_busy) : ps_read_avail;

    assign w_rd_be     = (r_state == S_WAIT_HI) ? r_be[3:2] : r_be[1:0];
    assign w_rd_masked = {ps_data_out[15:8] & {8{w_rd_be[1]}},
                          ps_data_out[7:0]  & {8{w_rd_be[0]}}};

    // NOTE: every signal assigned in always_comb gets a default first so
    // that no path leaves it unassigned and infers a latch.
    always_comb begin
        w_shadow_next = r_shadow;
        if (!r_we && ps_read_avail) begin
            if (r_state == S_WAIT_LO) w_shadow_next[15:0]  = w_rd_masked;
            if (r_state == S_WAIT_HI) w_shadow_next[31:16] = w_rd_masked;
        end
    end

    // Command pulses are registered, so the decision to fire is made one
    // cycle ahead of the pulse, using the busy flag sampled in that cycle.
    always_comb begin
        w_fire = 1'b0;
        case (r_state)
            S_IDLE:     w_fire = req_valid & (w_lo_needed | w_hi_needed) & ~ps_busy;
            S_ISSUE_LO,
            S_ISSUE_HI: w_fire = ~w_pulsing & ~ps_busy;
            S_WAIT_LO:  w_fire = w_wait_done & w_hi_needed & ~ps_busy;
            default:    w_fire = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= S_IDLE;
            r_we               <= 1'b0;
            r_word_addr        <= '0;
            r_wdata            <= '0;
            r_be               <= '0;
            r_shadow           <= '0;
            r_cnt              <= '0;
            req_ready          <= 1'b0;
            req_err            <= 1'b0;
            rdata              <= '0;
            ps_addr            <= '0;
            ps_write_en        <= 1'b0;
            ps_read_en         <= 1'b0;
            ps_data_in         <= '0;
            ps_write_high_byte <= 1'b0;
            ps_write_low_byte  <= 1'b0;
        end else begin
            ps_write_en <= 1'b0;
            ps_read_en  <= 1'b0;
            req_ready   <= 1'b0;
            req_err     <= 1'b0;

            if (w_fire) begin
                ps_addr            <= {w_word_addr, w_cmd_hi};
                ps_data_in         <= w_cmd_hi ? w_wdata[31:16] : w_wdata[15:0];
                ps_write_high_byte <= w_cmd_hi ? w_be[3] : w_be[1];
                ps_write_low_byte  <= w_cmd_hi ? w_be[2] : w_be[0];
                ps_write_en        <= w_we;
                ps_read_en         <= ~w_we;
            end

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_word_addr <= req_addr[22:2];
                        r_wdata     <= req_wdata;
                        r_be        <= req_be;
                        r_shadow    <= '0;
                        if (w_lo_needed) begin
                            r_state <= S_ISSUE_LO;
                        end else if (w_hi_needed) begin
                            r_state <= S_ISSUE_HI;
                        end else begin
                            r_state   <= S_DONE;
                            req_ready <= 1'b1;
                            rdata     <= '0;
                        end
                    end
                end
                S_ISSUE_LO, S_ISSUE_HI: begin
                    // The pulse is on the bus this cycle; move on to wait.
                    if (w_pulsing) begin
                        r_state <= (r_state == S_ISSUE_LO) ? S_WAIT_LO : S_WAIT_HI;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT_LO, S_WAIT_HI: begin
                    r_shadow <= w_shadow_next;
                    if (w_wait_done) begin
                        if (r_state == S_WAIT_LO && w_hi_needed) begin
                            r_state <= S_ISSUE_HI;
                        end else begin
                            r_state   <= S_DONE;
                            req_ready <= 1'b1;
                            rdata     <= w_shadow_next;
                        end
                    end else if (r_cnt == C_WAIT_LAST) begin
                        r_state   <= S_ERR;
                        req_ready <= 1'b1;
                        req_err   <= 1'b1;
                        rdata     <= r_shadow;
                    end else begin
                        r_cnt <= r_cnt + 11'd1;
                    end
                end
                S_DONE, S_ERR: r_state <= S_IDLE;
                default:       r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_data_bridge.sv
// ============================================================================
// tb_psram_data_bridge
// ----------------------------------------------------------------------------
// Directed testbench for psram_data_bridge. A small PSRAM controller model
// answers writes with one busy cycle and reads with data three cycles after
// the read pulse. Each scenario task drives its own stimulus and compares
// against hand-computed expected values.
// ============================================================================
module tb_psram_data_bridge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, req_err, stall;
    logic [31:0] rdata;
    logic [21:0] ps_addr;
    logic        ps_write_en, ps_read_en, ps_write_high_byte, ps_write_low_byte;
    logic [15:0] ps_data_in, ps_data_out;
    logic        ps_read_avail, ps_busy;

    int asserts  = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psram_data_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .req_ready(req_ready), .req_err(req_err), .rdata(rdata), .stall(stall),
        .ps_addr(ps_addr), .ps_write_en(ps_write_en), .ps_read_en(ps_read_en),
        .ps_data_in(ps_data_in), .ps_write_high_byte(ps_write_high_byte),
        .ps_write_low_byte(ps_write_low_byte), .ps_read_avail(ps_read_avail),
        .ps_data_out(ps_data_out), .ps_busy(ps_busy)
    );

    // ---------------- PSRAM controller model ----------------
    typedef struct {
        logic [21:0] addr;
        logic [15:0] data;
        logic        hb;
        logic        lb;
        int          cyc;
    } cmd_t;

    cmd_t        wr_log[$];
    cmd_t        rd_log[$];
    logic [15:0] mem [0:63];
    int          busy_left;
    int          rd_left;
    logic [5:0]  rd_idx;
    logic        busy_hold = 1'b0;
    logic        rd_enable = 1'b1;

    assign ps_busy       = busy_hold | (busy_left != 0);
    assign ps_read_avail = rd_enable && (rd_left == 1);
    assign ps_data_out   = ps_read_avail ? mem[rd_idx] : 16'h0000;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_left <= 0;
            rd_left   <= 0;
            rd_idx    <= '0;
        end else begin
            if (busy_left != 0) busy_left <= busy_left - 1;
            if (rd_left != 0)   rd_left   <= rd_left - 1;
            if (ps_write_en) begin
                busy_left <= 1;
                if (ps_write_high_byte) mem[ps_addr[5:0]][15:8] <= ps_data_in[15:8];
                if (ps_write_low_byte)  mem[ps_addr[5:0]][7:0]  <= ps_data_in[7:0];
            end
            if (ps_read_en) begin
                rd_left <= 3;
                rd_idx  <= ps_addr[5:0];
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n && ps_write_en)
            wr_log.push_back('{ps_addr, ps_data_in, ps_write_high_byte, ps_write_low_byte, cyc});
        if (reset_n && ps_read_en)
            rd_log.push_back('{ps_addr, ps_data_in, ps_write_high_byte, ps_write_low_byte, cyc});
    end

    // ---------------- Request driver (no checking) ----------------
    // lat is the number of cycles from the accept cycle to the req_ready cycle.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output int lat, output logic [31:0] rd,
                          output logic err, output bit stall_ok, output bit tmo);
        bit done;
        @(posedge clk);
        #1;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        lat = 0; rd = '0; err = 1'b0; stall_ok = 1'b1; tmo = 1'b1; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1'b1; tmo = 1'b0; rd = rdata; err = req_err;
                if (stall !== 1'b0) stall_ok = 1'b0;
            end else begin
                if (stall !== 1'b1) stall_ok = 1'b0;
                lat++;
            end
        end
    endtask

    task automatic idle_req();
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // ---------------- Scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        asserts++;
        if ({req_ready, req_err, stall, ps_write_en, ps_read_en} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {req_ready, req_err, stall, ps_write_en, ps_read_en});
        end
        asserts++;
        if (rdata !== 32'h0) begin
            failures++; $display("FAIL reset_rdata: got %h expected 00000000", rdata);
        end
        asserts++;
        if ({ps_addr, ps_data_in, ps_write_high_byte, ps_write_low_byte} !== 40'h0) begin
            failures++;
            $display("FAIL reset_ps_fields: addr %h data %h strobes %b%b expected all 0",
                     ps_addr, ps_data_in, ps_write_high_byte, ps_write_low_byte);
        end
    endtask

    task automatic test_word_store();
        int lat; logic [31:0] rd; logic err; bit sok, tmo;
        wr_log.delete(); rd_log.delete();
        access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, lat, rd, err, sok, tmo);
        idle_req();
        asserts++;
        if (tmo || lat != 7) begin
            failures++; $display("FAIL store_latency: got %0d (timeout %0d) expected 7", lat, tmo);
        end
        asserts++;
        if (err !== 1'b0 || !sok) begin
            failures++; $display("FAIL store_err_stall: err %b stall_ok %0d expected 0/1", err, sok);
        end
        asserts++;
        if (wr_log.size() != 2 || rd_log.size() != 0) begin
            failures++;
            $display("FAIL store_pulse_count: writes %0d reads %0d expected 2/0",
                     wr_log.size(), rd_log.size());
        end else begin
            asserts++;
            if (wr_log[0].addr !== 22'h8 || wr_log[0].data !== 16'hBEEF ||
                {wr_log[0].hb, wr_log[0].lb} !== 2'b11) begin
                failures++;
                $display("FAIL store_lo_cmd: addr %h data %h strobes %b%b expected 000008 beef 11",
                         wr_log[0].addr, wr_log[0].data, wr_log[0].hb, wr_log[0].lb);
            end
            asserts++;
            if (wr_log[1].addr !== 22'h9 || wr_log[1].data !== 16'hDEAD ||
                {wr_log[1].hb, wr_log[1].lb} !== 2'b11) begin
                failures++;
                $display("FAIL store_hi_cmd: addr %h data %h strobes %b%b expected 000009 dead 11",
                         wr_log[1].addr, wr_log[1].data, wr_log[1].hb, wr_log[1].lb);
            end
            asserts++;
            if (wr_log[1].cyc - wr_log[0].cyc != 3) begin
                failures++;
                $display("FAIL store_pulse_spacing: got %0d expected 3",
                         wr_log[1].cyc - wr_log[0].cyc);
            end
        end
    endtask

    task automatic test_word_load();
        int lat; logic [31:0] rd; logic err; bit sok, tmo;
        // Full word: pulse +1, data +4, high pulse +5, data +8, ready +9.
        rd_log.delete(); wr_log.delete();
        access(1'b0, 32'h0000_0010, 32'h0, 4'hF, lat, rd, err, sok, tmo);
        idle_req();
        asserts++;
        if (tmo || rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
            failures++; $display("FAIL load_word_data: got %h err %b expected deadbeef 0", rd, err);
        end
        asserts++;
        if (lat != 9 || rd_log.size() != 2 || wr_log.size() != 0 || !sok) begin
            failures++;
            $display("FAIL load_word_timing: latency %0d reads %0d writes %0d stall_ok %0d expected 9 2 0 1",
                     lat, rd_log.size(), wr_log.size(), sok);
        end
        // Low half only: pulse +1, data +4, ready +5.
        rd_log.delete();
        access(1'b0, 32'h0000_0010, 32'h0, 4'b0011, lat, rd, err, sok, tmo);
        idle_req();
        asserts++;
        if (tmo || rd !== 32'h0000_BEEF) begin
            failures++; $display("FAIL load_half_data: got %h expected 0000beef", rd);
        end
        asserts++;
        if (lat != 5 || rd_log.size() != 1) begin
            failures++;
            $display("FAIL load_half_pulses: latency %0d reads %0d expected 5 1", lat, rd_log.size());
        end else begin
            asserts++;
            if (rd_log[0].addr !== 22'h8) begin
                failures++; $display("FAIL load_half_addr: got %h expected 000008", rd_log[0].addr);
            end
        end
    endtask

    task automatic test_be_zero();
        int lat; logic [31:0] rd; logic err; bit sok, tmo;
        rd_log.delete(); wr_log.delete();
        access(1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, rd, err, sok, tmo);
        idle_req();
        asserts++;
        if (tmo || lat != 1 || rd !== 32'h0 || err !== 1'b0) begin
            failures++;
            $display("FAIL be_zero: latency %0d rdata %h err %b expected 1 00000000 0", lat, rd, err);
        end
        asserts++;
        if (rd_log.size() != 0 || wr_log.size() != 0) begin
            failures++;
            $display("FAIL be_zero_traffic: reads %0d writes %0d expected 0 0",
                     rd_log.size(), wr_log.size());
        end
    endtask

    task automatic test_byte_store();
        int lat; logic [31:0] rd; logic err; bit sok, tmo;
        wr_log.delete();
        access(1'b1, 32'h0000_0010, 32'h00AB_0000, 4'b0100, lat, rd, err, sok, tmo);
        idle_req();
        asserts++;
        if (tmo || lat != 4 || wr_log.size() != 1) begin
            failures++;
            $display("FAIL byte_store_count: latency %0d writes %0d expected 4 1", lat, wr_log.size());
        end else begin
            asserts++;
            if (wr_log[0].addr !== 22'h9 || wr_log[0].data !== 16'h00AB ||
                {wr_log[0].hb, wr_log[0].lb} !== 2'b01) begin
                failures++;
                $display("FAIL byte_store_cmd: addr %h data %h strobes %b%b expected 000009 00ab 01",
                         wr_log[0].addr, wr_log[0].data, wr_log[0].hb, wr_log[0].lb);
            end
        end
    endtask

    task automatic test_busy_hold();
        bit early = 1'b0, sok = 1'b1, done = 1'b0;
        int ready_at = -1;
        wr_log.delete();
        @(posedge clk);
        #1;
        busy_hold = 1'b1;
        req_we = 1'b1; req_addr = 32'h0000_0020; req_wdata = 32'h0000_1234; req_be = 4'b0011;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ps_write_en !== 1'b0) early = 1'b1;
            if (stall !== 1'b1) sok = 1'b0;
        end
        @(posedge clk);
        #1 busy_hold = 1'b0;
        @(negedge clk);
        if (ps_write_en !== 1'b0) early = 1'b1;
        if (stall !== 1'b1) sok = 1'b0;
        asserts++;
        if (early) begin
            failures++; $display("FAIL busy_hold_early: pulse seen while busy, expected none");
        end
        @(negedge clk);
        asserts++;
        if (ps_write_en !== 1'b1 || ps_addr !== 22'h10 || ps_data_in !== 16'h1234) begin
            failures++;
            $display("FAIL busy_hold_pulse: en %b addr %h data %h expected 1 000010 1234",
                     ps_write_en, ps_addr, ps_data_in);
        end
        for (int i = 7; i < 60 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin done = 1'b1; ready_at = i; end
            else if (stall !== 1'b1) sok = 1'b0;
        end
        idle_req();
        asserts++;
        if (ready_at != 9 || wr_log.size() != 1 || !sok) begin
            failures++;
            $display("FAIL busy_hold_done: ready cycle %0d writes %0d stall_ok %0d expected 9 1 1",
                     ready_at, wr_log.size(), sok);
        end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] rd; logic err; bit sok, tmo;
        rd_enable = 1'b0;
        access(1'b0, 32'h0000_0010, 32'h0, 4'hF, lat, rd, err, sok, tmo);
        rd_enable = 1'b1;
        idle_req();
        asserts++;
        if (tmo || err !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL timeout_err: timeout %0d err %b rdata %h expected 0 1 00000000", tmo, err, rd);
        end
        @(negedge clk);
        asserts++;
        if (req_ready !== 1'b0 || req_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse_width: ready %b err %b expected 0 0", req_ready, req_err);
        end
        access(1'b0, 32'h0000_0010, 32'h0, 4'b0011, lat, rd, err, sok, tmo);
        idle_req();
        asserts++;
        if (tmo || err !== 1'b0 || rd !== 32'h0000_BEEF) begin
            failures++;
            $display("FAIL timeout_recover: err %b rdata %h expected 0 0000beef", err, rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic err; bit sok, tmo;
        access(1'b1, 32'h0000_0030, 32'hA5A5_5A5A, 4'hF, lat, rd, err, sok, tmo);
        // The load follows with req_valid held high straight through.
        access(1'b0, 32'h0000_0030, 32'h0, 4'hF, lat, rd, err, sok, tmo);
        idle_req();
        asserts++;
        if (tmo || lat != 9 || rd !== 32'hA5A5_5A5A || !sok) begin
            failures++;
            $display("FAIL back_to_back: latency %0d rdata %h stall_ok %0d expected 9 a5a55a5a 1",
                     lat, rd, sok);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic err; bit sok, tmo;
        bit found = 1'b0;
        @(posedge clk);
        #1;
        req_we = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'h1111_2222; req_be = 4'hF;
        req_valid = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ps_write_en && ps_addr[0]) found = 1'b1;
        end
        asserts++;
        if (!found) begin
            failures++; $display("FAIL reset_mid_reach: high-half pulse not seen within 40 cycles");
        end
        @(negedge clk);
        #1;
        reset_n = 1'b0; req_valid = 1'b0;
        #1;
        asserts++;
        if ({req_ready, req_err, stall, ps_write_en, ps_read_en} !== 5'b0 || rdata !== 32'h0 ||
            {ps_addr, ps_data_in, ps_write_high_byte, ps_write_low_byte} !== 40'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs: flags %b rdata %h addr %h data %h expected all 0",
                     {req_ready, req_err, stall, ps_write_en, ps_read_en}, rdata, ps_addr, ps_data_in);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        wr_log.delete();
        access(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, lat, rd, err, sok, tmo);
        idle_req();
        asserts++;
        if (tmo || lat != 7 || err !== 1'b0 || wr_log.size() != 2) begin
            failures++;
            $display("FAIL reset_mid_recover: latency %0d err %b writes %0d expected 7 0 2",
                     lat, err, wr_log.size());
        end else begin
            asserts++;
            if (wr_log[0].addr !== 22'h20 || wr_log[0].data !== 16'hF00D ||
                wr_log[1].addr !== 22'h21 || wr_log[1].data !== 16'hCAFE) begin
                failures++;
                $display("FAIL reset_mid_cmds: %h/%h then %h/%h expected 000020/f00d then 000021/cafe",
                         wr_log[0].addr, wr_log[0].data, wr_log[1].addr, wr_log[1].data);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_word_store();
        test_word_load();
        test_be_zero();
        test_byte_store();
        test_busy_hold();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
